// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace emitter: FSM states, ASCII constants,
// record kind encoding and the hex-nibble-to-ASCII helper.
package cpu_trace_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CARET,
    ST_TIME,
    ST_AT,
    ST_PC,
    ST_COLON,
    ST_SP1,
    ST_MARK,
    ST_OPER,
    ST_SP2,
    ST_LT,
    ST_EQ,
    ST_SP3,
    ST_DATA,
    ST_HASH
  } state_t;

  typedef enum logic {
    KIND_REG = 1'b0,
    KIND_MEM = 1'b1
  } kind_t;

  localparam logic [7:0] CH_CARET  = 8'h5e;  // '^'
  localparam logic [7:0] CH_AT     = 8'h40;  // '@'
  localparam logic [7:0] CH_COLON  = 8'h3a;  // ':'
  localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$'
  localparam logic [7:0] CH_STAR   = 8'h2a;  // '*'
  localparam logic [7:0] CH_LT     = 8'h3c;  // '<'
  localparam logic [7:0] CH_EQ     = 8'h3d;  // '='
  localparam logic [7:0] CH_HASH   = 8'h23;  // '#'
  localparam logic [7:0] CH_SPACE  = 8'h20;  // ' '
  localparam logic [7:0] CH_ZERO   = 8'h30;  // '0'

  localparam logic [13:0] TIME_MAX = 14'd9999;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return CH_ZERO + {4'h0, nib};
    else             return 8'h57 + {4'h0, nib};  // 'a' - 10
  endfunction

endpackage

// File: rtl/cpu_trace_bin2bcd.sv
// Combinational double-dabble: 14-bit binary (0..9999) to four BCD digits.
module cpu_trace_bin2bcd (
  input  logic [13:0] bin,
  output logic [15:0] bcd
);

  logic [29:0] sr;

  always_comb begin
    // NOTE: every combinational output gets a value before any branch, so no latch is inferred.
    sr = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sr[14 + 4*d +: 4] >= 4'd5) sr[14 + 4*d +: 4] = sr[14 + 4*d +: 4] + 4'd3;
      end
      sr = sr << 1;
    end
    bcd = sr[29:14];
  end

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serialises one CPU trace record per line as ASCII, one character per cycle.
// Optional macro TRACE_SPACE_EN inserts spaces after ':' and around "<=".
module cpu_trace_emitter
  import cpu_trace_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_kind,
  input  logic [15:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_grf,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  char_out,
  output logic        char_valid,
  output logic        line_done
);

  state_t      state, state_nx;
  logic [2:0]  idx, idx_nx;

  kind_t       kind_r;
  logic [13:0] time_r;
  logic [31:0] pc_r, addr_r, data_r;
  logic [4:0]  grf_r;

  logic [15:0] bcd;
  logic [2:0]  time_msd;
  logic [1:0]  grf_tens;
  logic [4:0]  grf_ones;
  logic        accept;

  assign accept = in_valid && in_ready;

  cpu_trace_bin2bcd u_bin2bcd (
    .bin (time_r),
    .bcd (bcd)
  );

  always_comb begin
    if      (bcd[15:12] != 4'd0) time_msd = 3'd3;
    else if (bcd[11:8]  != 4'd0) time_msd = 3'd2;
    else if (bcd[7:4]   != 4'd0) time_msd = 3'd1;
    else                         time_msd = 3'd0;
  end

  always_comb begin
    if (grf_r >= 5'd30)      begin grf_tens = 2'd3; grf_ones = grf_r - 5'd30; end
    else if (grf_r >= 5'd20) begin grf_tens = 2'd2; grf_ones = grf_r - 5'd20; end
    else if (grf_r >= 5'd10) begin grf_tens = 2'd1; grf_ones = grf_r - 5'd10; end
    else                     begin grf_tens = 2'd0; grf_ones = grf_r;         end
  end

  // NOTE: record registers carry no reset; they are only read after a capture has loaded them.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      kind_r <= kind_t'(in_kind);
      time_r <= (in_time > {2'b00, TIME_MAX}) ? TIME_MAX : in_time[13:0];
      pc_r   <= in_pc;
      grf_r  <= in_grf;
      addr_r <= in_addr;
      data_r <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state <= ST_IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      ST_IDLE:  if (in_valid) state_nx = ST_CARET;
      ST_CARET: begin state_nx = ST_TIME; idx_nx = time_msd; end
      ST_TIME:  if (idx == 3'd0) state_nx = ST_AT; else idx_nx = idx - 3'd1;
      ST_AT:    begin state_nx = ST_PC; idx_nx = 3'd7; end
      ST_PC:    if (idx == 3'd0) state_nx = ST_COLON; else idx_nx = idx - 3'd1;
`ifdef TRACE_SPACE_EN
      ST_COLON: state_nx = ST_SP1;
`else
      ST_COLON: state_nx = ST_MARK;
`endif
      ST_SP1:   state_nx = ST_MARK;
      ST_MARK: begin
        state_nx = ST_OPER;
        idx_nx   = (kind_r == KIND_MEM) ? 3'd7 : ((grf_tens != 2'd0) ? 3'd1 : 3'd0);
      end
      ST_OPER: begin
        if (idx == 3'd0) begin
`ifdef TRACE_SPACE_EN
          state_nx = ST_SP2;
`else
          state_nx = ST_LT;
`endif
        end else begin
          idx_nx = idx - 3'd1;
        end
      end
      ST_SP2:   state_nx = ST_LT;
      ST_LT:    state_nx = ST_EQ;
`ifdef TRACE_SPACE_EN
      ST_EQ:    state_nx = ST_SP3;
`else
      ST_EQ:    begin state_nx = ST_DATA; idx_nx = 3'd7; end
`endif
      ST_SP3:   begin state_nx = ST_DATA; idx_nx = 3'd7; end
      ST_DATA:  if (idx == 3'd0) state_nx = ST_HASH; else idx_nx = idx - 3'd1;
      // A record offered while '#' is on the wire starts the next line without a gap.
      ST_HASH:  state_nx = in_valid ? ST_CARET : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    char_valid = 1'b1;
    char_out   = 8'h00;
    line_done  = 1'b0;
    in_ready   = 1'b0;
    case (state)
      ST_IDLE:  begin char_valid = 1'b0; in_ready = 1'b1; end
      ST_CARET: char_out = CH_CARET;
      ST_TIME:  char_out = CH_ZERO + {4'h0, bcd[{idx[1:0], 2'b00} +: 4]};
      ST_AT:    char_out = CH_AT;
      ST_PC:    char_out = hex_char(pc_r[{idx, 2'b00} +: 4]);
      ST_COLON: char_out = CH_COLON;
      ST_SP1, ST_SP2, ST_SP3: char_out = CH_SPACE;
      ST_MARK:  char_out = (kind_r == KIND_MEM) ? CH_STAR : CH_DOLLAR;
      ST_OPER: begin
        if (kind_r == KIND_MEM)  char_out = hex_char(addr_r[{idx, 2'b00} +: 4]);
        else if (idx == 3'd1)    char_out = CH_ZERO + {6'd0, grf_tens};
        else                     char_out = CH_ZERO + {3'd0, grf_ones};
      end
      ST_LT:    char_out = CH_LT;
      ST_EQ:    char_out = CH_EQ;
      ST_DATA:  char_out = hex_char(data_r[{idx, 2'b00} +: 4]);
      ST_HASH:  begin char_out = CH_HASH; line_done = 1'b1; in_ready = 1'b1; end
      default:  char_valid = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Self-checking bench for cpu_trace_emitter: directed lines, boundaries,
// randomized records against a string-formatting model, back-to-back and mid-line reset.
module tb_cpu_trace_emitter;

  typedef struct {
    bit          kind;
    bit [15:0]   tim;
    bit [31:0]   pc;
    bit [4:0]    grf;
    bit [31:0]   addr;
    bit [31:0]   data;
  } rec_t;

`ifdef TRACE_SPACE_EN
  localparam string SP = " ";
`else
  localparam string SP = "";
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_kind;
  logic [15:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_grf;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        line_done;

  int n_tests = 0;
  int n_fail  = 0;

  rec_t  q_rec[$];
  string q_exp[$];

  always #5 clk = ~clk;

  cpu_trace_emitter dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_time    (in_time),
    .in_pc      (in_pc),
    .in_grf     (in_grf),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .char_out   (char_out),
    .char_valid (char_valid),
    .line_done  (line_done)
  );

  // Reference formatting straight from the line grammar.
  function automatic string fmt_line(input rec_t r);
    string s;
    int    t;
    t = (r.tim > 16'd9999) ? 9999 : int'(r.tim);
    s = $sformatf("^%0d@%08x:%s", t, r.pc, SP);
    if (r.kind) s = {s, $sformatf("*%08x", r.addr)};
    else        s = {s, $sformatf("$%0d", r.grf)};
    s = {s, SP, "<=", SP, $sformatf("%08x#", r.data)};
    return s;
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.kind = 1'($urandom_range(0, 1));
    r.tim  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9999));
    r.pc   = $urandom;
    r.grf  = 5'($urandom_range(0, 31));
    r.addr = $urandom;
    r.data = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input rec_t r, input bit v);
    in_valid = v;
    in_kind  = r.kind;
    in_time  = r.tim;
    in_pc    = r.pc;
    in_grf   = r.grf;
    in_addr  = r.addr;
    in_data  = r.data;
  endtask

  task automatic check_idle(input string name);
    n_tests++;
    if (char_valid !== 1'b0 || char_out !== 8'h00 || line_done !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: valid=%b char=%h done=%b ready=%b, required valid=0 char=00 done=0 ready=1",
               name, char_valid, char_out, line_done, in_ready);
    end
  endtask

  // Emits every record in q_rec back-to-back (valid held across lines) and
  // checks each cycle against the matching string in q_exp.
  task automatic run_stream(input string name);
    int   budget;
    rec_t junk;
    budget = 0;
    while (in_ready !== 1'b1 && budget < 50) begin step(); budget++; end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_wait: in_ready=%b after %0d cycles, required 1", name, in_ready, budget);
      return;
    end
    drive(q_rec[0], 1'b1);
    step();
    for (int r = 0; r < q_rec.size(); r++) begin
      string s;
      s = q_exp[r];
      for (int i = 0; i < s.len(); i++) begin
        junk = rand_rec();
        if (r + 1 < q_rec.size()) drive(q_rec[r+1], 1'b1);
        else                      drive(junk, 1'b0);
        n_tests++;
        if (char_valid !== 1'b1 || char_out !== s[i] || line_done !== (i == s.len() - 1) ||
            in_ready !== (i == s.len() - 1)) begin
          n_fail++;
          $display("FAIL %s line%0d char%0d: valid=%b char=%h done=%b ready=%b, required valid=1 char=%h done=%b ready=%b (%s)",
                   name, r, i, char_valid, char_out, line_done, in_ready, s[i],
                   (i == s.len() - 1), (i == s.len() - 1), s);
        end
        step();
      end
    end
    check_idle({name, "_after"});
  endtask

  task automatic test_reset();
    check_idle("reset_state");
  endtask

  task automatic test_reg_line();
    rec_t r;
    r = '{kind: 1'b0, tim: 16'd1, pc: 32'h00003000, grf: 5'd5, addr: 32'h0, data: 32'h0000abcd};
    q_rec = {r};
`ifdef TRACE_SPACE_EN
    q_exp = {"^1@00003000: $5 <= 0000abcd#"};
`else
    q_exp = {"^1@00003000:$5<=0000abcd#"};
`endif
    run_stream("reg_line");
  endtask

  task automatic test_mem_line();
    rec_t r;
    r = '{kind: 1'b1, tim: 16'd2023, pc: 32'h00003004, grf: 5'd0, addr: 32'h00000010, data: 32'hdeadbeef};
    q_rec = {r};
    q_exp = {{"^2023@00003004:", SP, "*00000010", SP, "<=", SP, "deadbeef#"}};
    run_stream("mem_line");
  endtask

  task automatic test_boundaries();
    rec_t a, b, c;
    a = '{kind: 1'b0, tim: 16'd0,     pc: 32'h00000100, grf: 5'd31, addr: 32'h0, data: 32'h00000001};
    b = '{kind: 1'b0, tim: 16'd12000, pc: 32'hffffffff, grf: 5'd0,  addr: 32'h0, data: 32'h12345678};
    c = '{kind: 1'b0, tim: 16'd10,    pc: 32'h0000000a, grf: 5'd20, addr: 32'h0, data: 32'hffffffff};
    q_rec = {a};
    q_exp = {{"^0@00000100:", SP, "$31", SP, "<=", SP, "00000001#"}};
    run_stream("time0_grf31");
    q_rec = {b};
    q_exp = {{"^9999@ffffffff:", SP, "$0", SP, "<=", SP, "12345678#"}};
    run_stream("time_clamp_grf0");
    q_rec = {c};
    q_exp = {{"^10@0000000a:", SP, "$20", SP, "<=", SP, "ffffffff#"}};
    run_stream("time10_grf20");
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      rec_t r;
      r = rand_rec();
      q_rec = {r};
      q_exp = {fmt_line(r)};
      run_stream($sformatf("random%0d", k));
    end
  endtask

  task automatic test_back_to_back();
    q_rec.delete();
    q_exp.delete();
    for (int k = 0; k < 3; k++) begin
      rec_t r;
      r = rand_rec();
      q_rec.push_back(r);
      q_exp.push_back(fmt_line(r));
    end
    run_stream("back_to_back");
  endtask

  task automatic test_reset_mid_line();
    rec_t  r, f;
    string s;
    r = rand_rec();
    s = fmt_line(r);
    drive(r, 1'b1);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(rand_rec(), 1'b0);
      n_tests++;
      if (char_valid !== 1'b1 || char_out !== s[i]) begin
        n_fail++;
        $display("FAIL reset_mid char%0d: valid=%b char=%h, required valid=1 char=%h",
                 i, char_valid, char_out, s[i]);
      end
      if (i < 9) step();
    end
    reset = 1'b1;
    drive(rand_rec(), 1'b1);
    step();
    reset = 1'b0;
    drive(rand_rec(), 1'b0);
    check_idle("reset_mid_next");
    step();
    check_idle("reset_ignores_valid");
    f = rand_rec();
    q_rec = {f};
    q_exp = {fmt_line(f)};
    run_stream("after_reset");
  endtask

  initial begin
    rec_t z;
    z = '{kind: 1'b0, tim: 16'd0, pc: 32'h0, grf: 5'd0, addr: 32'h0, data: 32'h0};
    reset = 1'b1;
    drive(z, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(z, 1'b0);
    test_reset();
    test_reg_line();
    test_mem_line();
    test_boundaries();
    test_random();
    test_back_to_back();
    test_reset_mid_line();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_trace_emitter.md
CPU_TRACE_EMITTER -- requirements
Module: cpu_trace_emitter

Interface
REQ-001 SHALL have clk, input, 1, rising-edge system clock.
REQ-002 SHALL have reset, input, 1; reset is synchronous, active-high; clock is clk.
REQ-003 SHALL have in_valid, input, 1, a trace record is offered.
REQ-004 SHALL have in_ready, output, 1, the emitter can accept a record this cycle.
REQ-005 SHALL have in_kind, input, 1, 0 = register write, 1 = memory write.
REQ-006 SHALL have in_time, input, 16, binary timestamp.
REQ-007 SHALL have in_pc, input, 32, instruction address.
REQ-008 SHALL have in_grf, input, 5, register number, used when in_kind=0.
REQ-009 SHALL have in_addr, input, 32, memory address, used when in_kind=1.
REQ-010 SHALL have in_data, input, 32, write data.
REQ-011 SHALL have char_out, output, 8, ASCII character.
REQ-012 SHALL have char_valid, output, 1, char_out is meaningful this cycle.
REQ-013 SHALL have line_done, output, 1, one-cycle pulse coincident with the '#' character.

Function
REQ-014 SHALL accept a record on any clk edge where in_valid && in_ready, capturing all in_* fields into internal registers.
REQ-015 SHALL emit exactly one character per cycle, with no backpressure, starting with '^' on the cycle after acceptance.
REQ-016 SHALL emit a register-write line as: ^ TIME @ PC8 : $ GRF < = DATA8 #.
REQ-017 SHALL emit a memory-write line as: ^ TIME @ PC8 : * ADDR8 < = DATA8 #.
REQ-018 SHALL format TIME in decimal, 1-4 digits, with leading zeros suppressed; time 0 emits "0".
REQ-019 SHALL clamp in_time values above 9999 to 9999.
REQ-020 SHALL format GRF in decimal, 1-2 digits, with leading zeros suppressed.
REQ-021 SHALL format PC8, ADDR8 and DATA8 as exactly 8 lowercase hex digits, most significant nibble first.
REQ-022 SHALL implement the FSM states IDLE, CARET, TIME, AT, PC, COLON, SP1, MARK, OPER, SP2, LT, EQ, SP3, DATA, HASH, with a 3-bit digit index counting within TIME, OPER, PC and DATA.
REQ-023 SHALL sequence the FSM linearly; SP1/SP2/SP3 are skipped when spacing is disabled.
REQ-024 SHALL make HASH go to CARET if a record is accepted in the same cycle, and to IDLE otherwise.
REQ-025 SHALL drive in_ready=1 in IDLE and in HASH, and 0 in all other states, so back-to-back lines have no gap.
REQ-026 SHALL drive char_valid=0 and char_out=8'h00 in IDLE.
REQ-027 SHALL never drop, corrupt or re-sample a record mid-line, because in_* changes after acceptance are ignored.

Reset
REQ-028 SHALL on reset go to IDLE with char_valid=0, char_out=8'h00, line_done=0 and in_ready=1 on the following cycle.
REQ-029 SHALL on reset mid-line abandon the partial line and emit no '#'.
REQ-030 SHALL ignore in_valid in the same cycle as reset.

Configuration
REQ-031 SHALL, when TRACE_SPACE_EN is defined, emit one space after ':', one before "<=", and one after "<=".
REQ-032 SHALL, when TRACE_SPACE_EN is undefined, emit no spaces anywhere in the line.

Structure
REQ-033 SHALL place the FSM state encoding, the ASCII constants ('^' '@' ':' '$' '*' '<' '=' '#' ' ') and the in_kind encoding in the shared package cpu_trace_pkg.
REQ-034 SHALL use the sub-module cpu_trace_bin2bcd, a combinational double-dabble of a 14-bit value to 4 BCD digits, instantiated once for TIME; GRF uses a two-digit compare against 10/20/30.
REQ-035 SHALL place the hex-nibble-to-ASCII conversion in a package function.

Verification
REQ-036 SHALL test: time=1, pc=0x00003000, kind=0, grf=5, data=0x0000abcd, macro off -> "^1@00003000:$5<=0000abcd#" over 25 consecutive cycles, with line_done on the last.
REQ-037 SHALL test: the same record with TRACE_SPACE_EN -> "^1@00003000: $5 <= 0000abcd#" over 28 cycles.
REQ-038 SHALL test: time=2023, pc=0x00003004, kind=1, addr=0x00000010, data=0xdeadbeef -> "^2023@00003004:*00000010<=deadbeef#" over 35 cycles.
REQ-039 SHALL test boundaries: time=0 -> "^0@"; time=12000 -> "^9999@"; grf=31 -> "$31"; grf=0 -> "$0".
REQ-040 SHALL test: two records held valid back-to-back -> the second '^' directly follows the first '#', and in_ready pulses only in IDLE/HASH.
REQ-041 SHALL test: reset asserted on the 10th character -> char_valid=0 next cycle, no '#', and a fresh record afterwards is emitted complete.
